// File: rtl/varredura_coluna_pkg.sv
// Shared definitions for the column scanner: FSM state encoding, column index width
// and the column-advance helper used by the scan stage.
package varredura_coluna_pkg;

  localparam int unsigned ColW = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StScan = 2'd1,
    StBlnk = 2'd2
  } state_e;

  // Next column index, wrapping from ncol-1 back to 0.
  function automatic logic [ColW-1:0] next_col(input logic [ColW-1:0] code,
                                               input int unsigned ncol);
    if (code == ColW'(ncol - 1)) begin
      return '0;
    end
    return code + ColW'(1);
  endfunction

endpackage

// File: rtl/varredura_coluna_divisor.sv
// Scan prescaler: counts lit cycles of a column, with count-enable, clear and a
// terminal-count flag raised when the count sits at DIV-1.
module divisor_varredura #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign tc_o = (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/varredura_coluna.sv
// LED matrix column scanner: lights one column at a time (active-low) for DIV cycles,
// separated by BLANK all-off cycles, with registered index, tick and frame outputs.
module varredura_coluna
  import varredura_coluna_pkg::*;
#(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned NCOL  = 5,
  parameter int unsigned BLANK = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            freeze,
  output logic [ColW-1:0] col_code,
  output logic [NCOL-1:0] col_sel,
  output logic            col_tick,
  output logic            frame_start
);

  localparam int unsigned BlankW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK - 1);

  state_e            state_q, state_d;
  logic [ColW-1:0]   col_code_q, col_code_d;
  logic [NCOL-1:0]   col_sel_q, col_sel_d;
  logic              col_tick_q, col_tick_d;
  logic              frame_start_q, frame_start_d;
  logic [BlankW-1:0] blank_cnt_q, blank_cnt_d;

  logic              pre_en, pre_clr, pre_tc;
  logic              col_done;
  logic [ColW-1:0]   col_nxt;
  logic [NCOL-1:0]   scan_sel;

  divisor_varredura #(
    .DIV (DIV)
  ) u_divisor (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (pre_en),
    .clr_i   (pre_clr),
    .tc_o    (pre_tc)
  );

  assign col_done = (state_q == StScan) && pre_tc && !freeze;
  assign pre_en   = (state_q == StScan) && !freeze;
  // Prescaler reads 0 everywhere outside SCAN and restarts on each column advance.
  assign pre_clr  = !enable || (state_q != StScan) || col_done;
  assign col_nxt  = next_col(col_code_q, NCOL);

  // Column decoder for the currently held index; IDLE always holds index 0.
  always_comb begin
    scan_sel = '1;
    for (int i = 0; i < NCOL; i++) begin
      if (col_code_q == ColW'(i)) begin
        scan_sel[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    col_code_d    = col_code_q;
    col_sel_d     = col_sel_q;
    col_tick_d    = 1'b0;
    frame_start_d = 1'b0;
    blank_cnt_d   = blank_cnt_q;

    if (!enable) begin
      state_d     = StIdle;
      col_code_d  = '0;
      col_sel_d   = '1;
      blank_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d       = StScan;
          col_code_d    = '0;
          col_sel_d     = scan_sel;
          col_tick_d    = 1'b1;
          frame_start_d = 1'b1;
        end
        StScan: begin
          col_sel_d = scan_sel;
          if (col_done) begin
            state_d       = StBlnk;
            col_code_d    = col_nxt;
            col_sel_d     = '1;
            col_tick_d    = 1'b1;
            frame_start_d = (col_nxt == '0);
            blank_cnt_d   = '0;
          end
        end
        StBlnk: begin
          col_sel_d = '1;
          if (blank_cnt_q == BlankLast) begin
            state_d     = StScan;
            col_sel_d   = scan_sel;
            blank_cnt_d = '0;
          end else begin
            blank_cnt_d = blank_cnt_q + BlankW'(1);
          end
        end
        default: begin
          state_d     = StIdle;
          col_code_d  = '0;
          col_sel_d   = '1;
          blank_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      col_code_q    <= '0;
      col_sel_q     <= '1;
      col_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
      blank_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      col_code_q    <= col_code_d;
      col_sel_q     <= col_sel_d;
      col_tick_q    <= col_tick_d;
      frame_start_q <= frame_start_d;
      blank_cnt_q   <= blank_cnt_d;
    end
  end

  assign col_code    = col_code_q;
  assign col_sel     = col_sel_q;
  assign col_tick    = col_tick_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_varredura_coluna.sv
// Bench for varredura_coluna: directed scenarios plus random enable/freeze/reset traffic,
// every cycle compared against a column-period position model.
module tb_varredura_coluna;

  localparam int unsigned DIV   = 4;
  localparam int unsigned NCOL  = 5;
  localparam int unsigned BLANK = 2;

  logic            clk = 1'b0;
  logic            reset_n, enable, freeze;
  logic [2:0]      col_code;
  logic [NCOL-1:0] col_sel;
  logic            col_tick, frame_start;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model: position within a column period; 0..BLANK-1 blanked, BLANK..BLANK+DIV-1 lit.
  bit m_on;
  int m_col;
  int m_pos;
  bit m_tick;
  bit m_frame;

  always #5 clk = ~clk;

  varredura_coluna #(
    .DIV   (DIV),
    .NCOL  (NCOL),
    .BLANK (BLANK)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .freeze      (freeze),
    .col_code    (col_code),
    .col_sel     (col_sel),
    .col_tick    (col_tick),
    .frame_start (frame_start)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NCOL-1:0] exp_sel();
    logic [NCOL-1:0] one;
    if (!m_on || m_pos < int'(BLANK)) return '1;
    one = NCOL'(1) << m_col;
    return ~one;
  endfunction

  task automatic model_update(input logic r, input logic e, input logic f);
    m_tick  = 1'b0;
    m_frame = 1'b0;
    if (!r || !e) begin
      m_on  = 1'b0;
      m_col = 0;
      m_pos = 0;
    end else if (!m_on) begin
      m_on    = 1'b1;
      m_col   = 0;
      m_pos   = BLANK;
      m_tick  = 1'b1;
      m_frame = 1'b1;
    end else if (!(f && m_pos >= int'(BLANK))) begin
      m_pos++;
      if (m_pos == int'(BLANK + DIV)) begin
        m_pos   = 0;
        m_col   = (m_col + 1) % NCOL;
        m_tick  = 1'b1;
        m_frame = (m_col == 0);
      end
    end
  endtask

  task automatic compare_all();
    check_eq("col_code", 32'(col_code), 32'(m_col));
    check_eq("col_sel", 32'(col_sel), 32'(exp_sel()));
    check_eq("col_tick", 32'(col_tick), 32'(m_tick));
    check_eq("frame_start", 32'(frame_start), 32'(m_frame));
    check_eq("sel_onehot", 32'($countones(~col_sel) <= 1), 32'(1));
  endtask

  task automatic step(input logic r, input logic e, input logic f);
    reset_n = r;
    enable  = e;
    freeze  = f;
    @(posedge clk);
    model_update(r, e, f);
    #1;
    compare_all();
  endtask

  // Run enabled until the DUT ticks into column col; ok stays 0 if it never does.
  task automatic wait_tick(input int col, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (col_tick === 1'b1 && int'(col_code) == col) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int len;
    reset_n = 1'b0;
    enable  = 1'b0;
    freeze  = 1'b0;
    m_on = 1'b0; m_col = 0; m_pos = 0; m_tick = 1'b0; m_frame = 1'b0;

    // Reset regardless of enable.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check_eq("reset_sel", 32'(col_sel), 32'(5'b11111));

    // Start-up and first column advance.
    step(1'b1, 1'b1, 1'b0);
    check_eq("first_sel", 32'(col_sel), 32'(5'b11110));
    check_eq("first_frame", 32'(frame_start), 32'(1));
    for (int c = 2; c <= 30; c++) begin
      step(1'b1, 1'b1, 1'b0);
      if (c == 5) check_eq("c5_sel", 32'(col_sel), 32'(5'b11111));
      if (c == 7) begin
        check_eq("c7_sel", 32'(col_sel), 32'(5'b11101));
        check_eq("c7_code", 32'(col_code), 32'(1));
      end
    end

    // Freeze 10 cycles inside the SCAN of column 2: column lasts 16 cycles.
    step(1'b1, 1'b0, 1'b0);
    wait_tick(2, ok);
    check_eq("wait_col2", 32'(ok), 32'(1));
    len = 1;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, (len >= 3 && len <= 12));
      if (col_tick === 1'b1) break;
      len++;
    end
    check_eq("col2_len", 32'(len), 32'(16));

    // Freeze from the first BLNK cycle: blanking still 2 cycles, then the column holds.
    wait_tick(1, ok);
    check_eq("wait_col1", 32'(ok), 32'(1));
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1);
    check_eq("frozen_sel", 32'(col_sel), 32'(5'b11101));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);

    // Disable during BLNK of column 3, then re-enable.
    wait_tick(3, ok);
    check_eq("wait_col3", 32'(ok), 32'(1));
    step(1'b1, 1'b0, 1'b0);
    check_eq("dis_code", 32'(col_code), 32'(0));
    check_eq("dis_sel", 32'(col_sel), 32'(5'b11111));
    step(1'b1, 1'b1, 1'b0);
    check_eq("reen_frame", 32'(frame_start), 32'(1));

    // Reset pulse mid-SCAN of column 4.
    wait_tick(4, ok);
    check_eq("wait_col4", 32'(ok), 32'(1));
    for (int i = 0; i < BLANK + 1; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_eq("rst_sel", 32'(col_sel), 32'(5'b11111));
    step(1'b1, 1'b1, 1'b0);
    check_eq("rst_restart", 32'(col_sel), 32'(5'b11110));

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 60) != 0, ($urandom % 25) != 0, ($urandom % 6) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
